prom_sequencer: RTL and testbench
=================================

# prom_sequencer

Pattern player that sits directly downstream of the 256×36 dual-port pattern PROM in the blinky10k example. It walks the PROM's read port (port B) one word at a time and drives an 8-bit LED register from each word. It holds each pattern for a per-word duration, measured in prescaled ticks, then fetches the next word, wrapping at a programmable last address or at a word carrying the end flag.

## Interface
- `TICK_DIV`, default 12000: clock cycles per hold tick; legal range 1..2^24-1.
- `RD_LAT`, default 1: cycles from `prom_addr` change to valid `prom_data`; legal range 1..3.
- `LAST_ADDR`, default 255: highest word address played before wrapping to 0.

Ports:
- `clk` in 1: single system clock; also clocks PROM port B.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: run when high; pause when low.
- `restart` in 1: synchronous request to restart from address 0.
- `prom_addr` out 13: PROM port B word address.
- `prom_data` in 36: PROM port B read data.
- `led` out 8: current pattern.
- `step` out 1: one-cycle pulse when `led` is loaded.
- `wrap` out 1: one-cycle pulse when the address wraps to 0.
- `busy` out 1: high in any state except IDLE.

## Operation
- Word format:
  - `prom_data[35]` is the end flag.
  - `[34:32]` are ignored.
  - `[31:24]` is the LED pattern.
  - `[23:0]` is the hold count `dur`. A `dur` of 0 is treated as 1.
- States:
  - IDLE. Go to FETCH when `enable`=1.
  - FETCH, 1 cycle. `prom_addr` holds the current address. Go to WAIT.
  - WAIT, exactly RD_LAT cycles. Go to LOAD.
  - LOAD, 1 cycle:
    - Capture `prom_data`: `led` ← `[31:24]`.
    - Hold counter ← max(`dur`,1); prescaler ← 0.
    - Latch the end flag.
    - Pulse `step`.
    - Go to HOLD.
  - HOLD:
    - Prescaler counts 0..TICK_DIV-1. On its terminal count, decrement the hold counter.
    - When the hold counter reaches 0, compute the next address and go to FETCH.
- Next address:
  - If the latched end flag = 1 or address = LAST_ADDR: next address is 0 and `wrap` pulses in that cycle.
  - Otherwise: address + 1.
  - `prom_addr` changes on the clock edge that enters FETCH.
- Pause (`enable`=0):
  - In HOLD, the prescaler and hold counter freeze, and `led` is held.
  - FETCH/WAIT/LOAD always complete; the block then stalls in HOLD.
  - `busy` stays high.
  - Resuming continues from the frozen counts with no lost or extra cycles.
- Restart (`restart`=1, sampled any cycle):
  - Takes priority over all other transitions.
  - Address ← 0; prescaler and hold counter ← 0.
  - Next state: FETCH if `enable`=1, else IDLE. `led` keeps its value.
  - Does not pulse `wrap`.
- Reset values: state IDLE, `prom_addr`=0, `led`=0, `step`=0, `wrap`=0, `busy`=0, all counters 0.
- `rst` asserted in any state overrides `restart` and aborts any fetch in progress.
- Counters: prescaler is 24 bits, hold counter is 24 bits. Neither counter wraps; both saturate at 0.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- From `enable` rising in IDLE to the first `step`: 2+RD_LAT cycles. FETCH is entered on the first edge; `step` is asserted in the LOAD cycle.
- Period between consecutive `step` pulses, with `enable` held high: max(`dur`,1)·TICK_DIV + RD_LAT + 2 cycles.
- `led` updates on the edge at the end of LOAD and is visible in the first HOLD cycle.
- `wrap` is asserted in the same cycle as the FETCH that presents address 0.
- `restart` sampled high at edge N: `prom_addr`=0 after edge N. If `enable`=1, `step` for word 0 occurs RD_LAT+1 cycles after edge N.
- Simultaneous hold-expiry and `restart`: restart wins; no `wrap` pulse.
- Simultaneous hold-expiry and `enable`=0: the expiry is not taken; the block stays in HOLD until `enable` returns.

## Test plan
- Reset, then `enable`=1, TICK_DIV=4, RD_LAT=1, word0={end=0, led=8'hA5, dur=3} → `step` at cycle 3, `led`=A5, next `step` 15 cycles later.
- Word with `dur`=0, TICK_DIV=4, RD_LAT=1 → held exactly 4 cycles (period 7).
- LAST_ADDR=2, end flags clear → addresses 0,1,2,0; `wrap` pulses once per lap, coincident with FETCH of address 0.
- End flag set on word 1, LAST_ADDR=255 → addresses 0,1,0,1; `wrap` after word 1 only.
- `enable` dropped for 10 cycles mid-HOLD → next `step` delayed by exactly 10 cycles; `led` stable; `busy`=1 throughout.
- `restart` asserted on the hold-expiry cycle of address 5, `enable`=1 → `prom_addr`=0 next cycle, no `wrap`, `step` RD_LAT+1 cycles later; repeat with `rst` in WAIT → all outputs 0 and state IDLE on the next cycle.

Source files
------------

// File: rtl/prom_sequencer.sv
// Pattern player for the blinky10k pattern PROM: fetches one 36-bit word at a time,
// drives the LED register from it and holds each pattern for a prescaled duration.
module prom_sequencer #(
  parameter int unsigned TICK_DIV  = 12000,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned LAST_ADDR = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        restart,
  output logic [12:0] prom_addr,
  input  logic [35:0] prom_data,
  output logic [7:0]  led,
  output logic        step,
  output logic        wrap,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_LOAD  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);
  localparam logic [1:0]  LAT_LAST  = 2'(RD_LAT - 1);
  localparam logic [12:0] ADDR_LAST = 13'(LAST_ADDR);

  // Counters never wrap below zero.
  function automatic logic [23:0] sat_dec(input logic [23:0] v);
    return (v == 24'd0) ? 24'd0 : v - 24'd1;
  endfunction

  state_t      state_r, state_s;
  logic [12:0] addr_r, addr_s;
  logic [23:0] presc_r, presc_s;
  logic [23:0] hold_r, hold_s;
  logic [1:0]  lat_r, lat_s;
  logic        end_r, end_s;
  logic [7:0]  led_r, led_s;
  logic        step_r, wrap_r, busy_r, wrap_s;
  logic        unused_bits_s;

  assign unused_bits_s = ^prom_data[34:32];

  // Next-state and datapath update; restart overrides every other transition.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    presc_s = presc_r;
    hold_s  = hold_r;
    lat_s   = lat_r;
    end_s   = end_r;
    led_s   = led_r;
    wrap_s  = 1'b0;
    if (restart) begin
      addr_s  = 13'd0;
      presc_s = 24'd0;
      hold_s  = 24'd0;
      state_s = enable ? S_FETCH : S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (enable) state_s = S_FETCH;
          else        state_s = S_IDLE;
        end
        S_FETCH: begin
          state_s = S_WAIT;
          lat_s   = 2'd0;
        end
        S_WAIT: begin
          if (lat_r == LAT_LAST) state_s = S_LOAD;
          else                   lat_s   = lat_r + 2'd1;
        end
        S_LOAD: begin
          led_s   = prom_data[31:24];
          hold_s  = (prom_data[23:0] == 24'd0) ? 24'd1 : prom_data[23:0];
          presc_s = 24'd0;
          end_s   = prom_data[35];
          state_s = S_HOLD;
        end
        S_HOLD: begin
          // A paused block freezes here, even on the cycle its hold would expire.
          if (!enable) begin
            state_s = S_HOLD;
          end else if (presc_r != TICK_LAST) begin
            presc_s = presc_r + 24'd1;
          end else begin
            presc_s = 24'd0;
            hold_s  = sat_dec(hold_r);
            if (hold_r <= 24'd1) begin
              state_s = S_FETCH;
              if (end_r || (addr_r == ADDR_LAST)) begin
                addr_s = 13'd0;
                wrap_s = 1'b1;
              end else begin
                addr_s = addr_r + 13'd1;
              end
            end else begin
              state_s = S_HOLD;
            end
          end
        end
        default: begin
          state_s = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers; step/busy are derived from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      addr_r  <= 13'd0;
      presc_r <= 24'd0;
      hold_r  <= 24'd0;
      lat_r   <= 2'd0;
      end_r   <= 1'b0;
      led_r   <= 8'd0;
      step_r  <= 1'b0;
      wrap_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      presc_r <= presc_s;
      hold_r  <= hold_s;
      lat_r   <= lat_s;
      end_r   <= end_s;
      led_r   <= led_s;
      step_r  <= (state_s == S_LOAD);
      wrap_r  <= wrap_s;
      busy_r  <= (state_s != S_IDLE);
    end
  end

  assign prom_addr = addr_r;
  assign led       = led_r;
  assign step      = step_r;
  assign wrap      = wrap_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_prom_sequencer.sv
// Randomized bench for prom_sequencer: a PROM array feeds the DUT and expected step
// times, addresses, LED values and wrap points are computed from the word contents.
module tb_prom_sequencer;
  localparam int TD   = 4;
  localparam int RL   = 1;
  localparam int LAST = 6;

  logic        clk = 1'b0;
  logic        rst, enable, restart;
  logic [12:0] prom_addr;
  logic [35:0] prom_data;
  logic [7:0]  led;
  logic        step, wrap, busy;

  logic [35:0] mem [0:255];
  int cyc  = 0;
  int vec  = 0;
  int errs = 0;
  int step_q[$], addr_q[$], led_q[$], wrap_q[$], wrapa_q[$];
  logic step_d = 1'b0;

  prom_sequencer #(.TICK_DIV(TD), .RD_LAT(RL), .LAST_ADDR(LAST)) dut (
    .clk(clk), .rst(rst), .enable(enable), .restart(restart),
    .prom_addr(prom_addr), .prom_data(prom_data), .led(led),
    .step(step), .wrap(wrap), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // One-cycle registered PROM read port
  always @(posedge clk) prom_data <= mem[prom_addr[7:0]];

  // Event recorder sampled on the inactive edge
  always @(negedge clk) begin
    if (step === 1'b1) begin
      step_q.push_back(cyc);
      addr_q.push_back(int'(prom_addr));
    end
    if (step_d) led_q.push_back(int'(led));
    if (wrap === 1'b1) begin
      wrap_q.push_back(cyc);
      wrapa_q.push_back(int'(prom_addr));
    end
    step_d <= (step === 1'b1);
  end

  function automatic void fill_mem(input int max_dur, input int end_pct);
    logic e;
    for (int j = 0; j < 256; j++) begin
      e = ($urandom_range(99) < end_pct);
      mem[j] = {e, 3'($urandom), 8'($urandom), 24'($urandom_range(max_dur, 0))};
    end
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; restart = 1'b0;
    repeat (3) tick();
    step_q.delete(); addr_q.delete(); led_q.delete(); wrap_q.delete(); wrapa_q.delete();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_step(input int budget, output int t, output bit ok);
    ok = 1'b0; t = -1;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (step === 1'b1) begin
        ok = 1'b1; t = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; restart = 1'b0;
    repeat (2) tick();
    vec++; if (prom_addr !== 13'd0) begin errs++; $display("FAIL reset_addr: got %0d want 0", prom_addr); end
    vec++; if (led !== 8'd0) begin errs++; $display("FAIL reset_led: got %0h want 0", led); end
    vec++; if ({step, wrap, busy} !== 3'b000) begin errs++; $display("FAIL reset_flags: got %b want 000", {step, wrap, busy}); end
    rst = 1'b0;
    repeat (4) tick();
    vec++; if ({step, busy} !== 2'b00) begin errs++; $display("FAIL idle_stays: got %b want 00", {step, busy}); end
  endtask

  // Plays n words from reset with enable held high and checks every step against the word contents
  task automatic test_play(input string name, input int n);
    int t0, exp_t, a, d, nw;
    bit ok;
    int exp_w[$];
    logic [35:0] w;
    do_reset();
    enable = 1'b1; t0 = cyc;
    exp_t = t0 + RL + 2; a = 0;
    for (int i = 0; i < n; i++) begin
      ok = 1'b0;
      for (int k = 0; k < 200 && !ok; k++) begin
        tick();
        if (led_q.size() > i) ok = 1'b1;
      end
      vec++;
      if (!ok) begin errs++; $display("FAIL %s_timeout: step %0d never seen, want cycle %0d", name, i, exp_t); enable = 1'b0; return; end
      w = mem[a];
      vec++; if (step_q[i] != exp_t) begin errs++; $display("FAIL %s_step_time[%0d]: got %0d want %0d", name, i, step_q[i] - t0, exp_t - t0); end
      vec++; if (addr_q[i] != a) begin errs++; $display("FAIL %s_addr[%0d]: got %0d want %0d", name, i, addr_q[i], a); end
      vec++; if (led_q[i] != int'(w[31:24])) begin errs++; $display("FAIL %s_led[%0d]: got %0h want %0h", name, i, led_q[i], w[31:24]); end
      d = int'(w[23:0]);
      if (d == 0) d = 1;
      if (w[35] || a == LAST) begin
        if (i < n - 1) exp_w.push_back(exp_t + 1 + d * TD);
        a = 0;
      end else begin
        a = a + 1;
      end
      exp_t = exp_t + d * TD + RL + 2;
    end
    vec++; if (busy !== 1'b1) begin errs++; $display("FAIL %s_busy: got %b want 1", name, busy); end
    enable = 1'b0;
    nw = 0;
    foreach (wrap_q[k]) begin
      if (wrap_q[k] < step_q[n-1]) begin
        vec++;
        if (nw >= exp_w.size() || wrap_q[k] != exp_w[nw]) begin errs++; $display("FAIL %s_wrap_time: got %0d want %0d", name, wrap_q[k] - t0, (nw < exp_w.size()) ? exp_w[nw] - t0 : -1); end
        vec++; if (wrapa_q[k] != 0) begin errs++; $display("FAIL %s_wrap_addr: got %0d want 0", name, wrapa_q[k]); end
        nw++;
      end
    end
    vec++; if (nw != exp_w.size()) begin errs++; $display("FAIL %s_wrap_count: got %0d want %0d", name, nw, exp_w.size()); end
  endtask

  task automatic test_first_word();
    fill_mem(4, 0);
    mem[0] = {1'b0, 3'b000, 8'hA5, 24'd3};
    test_play("first", 3);
  endtask

  task automatic test_dur_zero();
    fill_mem(4, 0);
    for (int j = 0; j < 8; j++) mem[j][23:0] = 24'd0;
    test_play("dur0", 9);
  endtask

  task automatic test_lap();
    fill_mem(5, 0);
    test_play("lap", 16);
  endtask

  task automatic test_end_flag();
    fill_mem(5, 0);
    mem[1][35] = 1'b1;
    test_play("endflag", 6);
  endtask

  task automatic test_random();
    fill_mem(4, 12);
    test_play("random", 24);
  endtask

  task automatic test_pause();
    int t0, ts, t1, t2;
    bit ok;
    logic [35:0] w0;
    fill_mem(3, 0);
    mem[0][23:0] = 24'd5;
    mem[1][23:0] = 24'd1;
    w0 = mem[0];
    do_reset();
    enable = 1'b1; t0 = cyc;
    wait_step(20, ts, ok);
    vec++; if (!ok || ts != t0 + 3) begin errs++; $display("FAIL pause_first_step: got %0d want %0d", ts - t0, 3); end
    repeat (3) tick();
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      vec++; if (led !== w0[31:24]) begin errs++; $display("FAIL pause_led: got %0h want %0h", led, w0[31:24]); end
      vec++; if (busy !== 1'b1) begin errs++; $display("FAIL pause_busy: got %b want 1", busy); end
      vec++; if (step !== 1'b0) begin errs++; $display("FAIL pause_step: got %b want 0", step); end
    end
    enable = 1'b1;
    wait_step(60, t1, ok);
    vec++; if (!ok || t1 != ts + 5 * TD + RL + 2 + 10) begin errs++; $display("FAIL pause_delay: got %0d want %0d", t1 - ts, 5 * TD + RL + 2 + 10); end
    vec++; if (prom_addr !== 13'd1) begin errs++; $display("FAIL pause_addr: got %0d want 1", prom_addr); end
    repeat (TD) tick();
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      vec++; if ({step, busy} !== 2'b01 || prom_addr !== 13'd1) begin errs++; $display("FAIL expiry_pause: got step/busy %b addr %0d want 01 addr 1", {step, busy}, prom_addr); end
    end
    enable = 1'b1;
    wait_step(30, t2, ok);
    vec++; if (!ok || t2 != t1 + TD + RL + 2 + 3) begin errs++; $display("FAIL expiry_resume: got %0d want %0d", t2 - t1, TD + RL + 2 + 3); end
    vec++; if (prom_addr !== 13'd2) begin errs++; $display("FAIL expiry_addr: got %0d want 2", prom_addr); end
    enable = 1'b0;
  endtask

  task automatic test_restart();
    int t0, t5, t;
    bit ok;
    logic [35:0] w0;
    fill_mem(1, 0);
    for (int j = 0; j < 8; j++) mem[j][23:0] = 24'd1;
    mem[0][31:24] = 8'h3C;
    w0 = mem[0];
    do_reset();
    enable = 1'b1; t0 = cyc;
    ok = 1'b0; t5 = -1;
    for (int i = 0; i < 6; i++) begin
      wait_step(40, t5, ok);
      if (!ok) break;
    end
    vec++; if (!ok || t5 != t0 + 3 + 5 * (TD + RL + 2)) begin errs++; $display("FAIL restart_reach5: got %0d want %0d", t5 - t0, 3 + 5 * (TD + RL + 2)); end
    vec++; if (prom_addr !== 13'd5) begin errs++; $display("FAIL restart_addr5: got %0d want 5", prom_addr); end
    repeat (TD) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    vec++; if (prom_addr !== 13'd0 || wrap !== 1'b0 || busy !== 1'b1) begin errs++; $display("FAIL restart_next: got addr %0d wrap %b busy %b want 0 0 1", prom_addr, wrap, busy); end
    wait_step(20, t, ok);
    vec++; if (!ok || t != t5 + TD + 1 + RL + 1) begin errs++; $display("FAIL restart_step: got %0d want %0d", t - t5, TD + 1 + RL + 1); end
    tick();
    vec++; if (led !== w0[31:24]) begin errs++; $display("FAIL restart_led: got %0h want %0h", led, w0[31:24]); end
    vec++; if (wrap_q.size() != 0) begin errs++; $display("FAIL restart_nowrap: got %0d want 0", wrap_q.size()); end
    enable = 1'b0; restart = 1'b1;
    tick();
    restart = 1'b0;
    vec++; if (busy !== 1'b0 || prom_addr !== 13'd0 || led !== w0[31:24]) begin errs++; $display("FAIL restart_idle: got busy %b addr %0d led %0h want 0 0 %0h", busy, prom_addr, led, w0[31:24]); end
    repeat (3) tick();
    vec++; if ({step, busy} !== 2'b00) begin errs++; $display("FAIL restart_idle_hold: got %b want 00", {step, busy}); end
    enable = 1'b1; t0 = cyc;
    wait_step(20, t, ok);
    vec++; if (!ok || t != t0 + RL + 2) begin errs++; $display("FAIL restart_resume: got %0d want %0d", t - t0, RL + 2); end
  endtask

  task automatic test_rst_in_wait();
    int t0, t;
    bit ok;
    tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    tick();
    vec++; if (step !== 1'b0 || busy !== 1'b1) begin errs++; $display("FAIL wait_state: got step %b busy %b want 0 1", step, busy); end
    rst = 1'b1; enable = 1'b0;
    tick();
    vec++; if (prom_addr !== 13'd0 || led !== 8'd0 || {step, wrap, busy} !== 3'b000) begin errs++; $display("FAIL rst_wait: got addr %0d led %0h flags %b want 0 0 000", prom_addr, led, {step, wrap, busy}); end
    rst = 1'b0;
    repeat (3) tick();
    vec++; if ({step, busy} !== 2'b00) begin errs++; $display("FAIL rst_idle: got %b want 00", {step, busy}); end
    enable = 1'b1; t0 = cyc;
    wait_step(20, t, ok);
    vec++; if (!ok || t != t0 + RL + 2) begin errs++; $display("FAIL rst_resume: got %0d want %0d", t - t0, RL + 2); end
    enable = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; restart = 1'b0;
    fill_mem(3, 0);
    test_reset();
    test_first_word();
    test_dur_zero();
    test_lap();
    test_end_flag();
    test_random();
    test_pause();
    test_restart();
    test_rst_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
